// File: rtl/cpu_pkg.sv
// Shared MIPS core constants: reset/exception vectors, fetch window and IF/ID layout.
// Fetch address checking is compiled in only when FETCH_ADDR_CHECK_EN is defined.
package cpu_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned EXCCODE_W = 5;

   localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_3000;
   localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_4180;
   localparam logic [XLEN-1:0] IM_BASE    = 32'h0000_3000;
   localparam int unsigned     IM_WORDS   = 2048;
   localparam logic [XLEN-1:0] IM_LAST    = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

   localparam logic [EXCCODE_W-1:0] EXC_ADEL = 5'd4;

   typedef enum logic [2:0] {
      NPC_SEQ,
      NPC_HOLD,
      NPC_BRANCH,
      NPC_EPC,
      NPC_VEC
   } npc_src_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [XLEN-1:0]    pc;
      logic [XLEN-1:0]    pc8;
      logic               bd;
      logic               valid;
   } if_id_t;

   function automatic logic fetch_addr_err(input logic [XLEN-1:0] pc);
      return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
   endfunction

endpackage

// File: rtl/fetch_npc_mux.sv
// Next-PC priority selector: exception > ERET > stall hold > ID redirect > sequential.
module fetch_npc_mux
   import cpu_pkg::*;
(
   input  logic [31:0] pc_f,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        stall,
   input  logic        npc_sel,
   input  logic [31:0] npc_target,
   output logic [31:0] npc
);

   npc_src_e src;

   always_comb begin
      src = NPC_SEQ;
      if (exc_req)      src = NPC_VEC;
      else if (eret)    src = NPC_EPC;
      else if (stall)   src = NPC_HOLD;
      else if (npc_sel) src = NPC_BRANCH;
   end

   always_comb begin
      npc = pc_f + 32'd4;
      case (src)
         NPC_VEC:    npc = EXC_VECTOR;
         NPC_EPC:    npc = epc;
         NPC_HOLD:   npc = pc_f;
         NPC_BRANCH: npc = npc_target;
         default:    npc = pc_f + 32'd4;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: program counter and IF/ID pipeline register.
// Define FETCH_ADDR_CHECK_EN to tag misaligned/out-of-range fetches as AdEL.
module fetch_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        npc_sel,
   input  logic [31:0] npc_target,
   input  logic        id_is_jb,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic [31:0] pc_f,
   input  logic [31:0] instr_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        bd_d,
   output logic        exc_d,
   output logic [4:0]  exccode_d,
   output logic        valid_d
);

   logic [31:0] pc_q;
   logic [31:0] npc;
   logic        flush;
   logic        fetch_err;
   if_id_t      if_id_q;
   if_id_t      if_id_n;

   assign flush = exc_req | eret;

   fetch_npc_mux u_npc_mux (
      .pc_f       (pc_q),
      .exc_req    (exc_req),
      .eret       (eret),
      .epc        (epc),
      .stall      (stall),
      .npc_sel    (npc_sel),
      .npc_target (npc_target),
      .npc        (npc)
   );

`ifdef FETCH_ADDR_CHECK_EN
   assign fetch_err = fetch_addr_err(pc_q);
`else
   assign fetch_err = 1'b0;
`endif

   // A faulting fetch enters IF/ID as a nop but keeps its address for EPC.
   always_comb begin
      if_id_n = if_id_q;
      if (flush) begin
         if_id_n = '0;
      end else if (!stall) begin
         if_id_n.instr = fetch_err ? '0 : instr_f;
         if_id_n.pc    = pc_q;
         if_id_n.pc8   = pc_q + 32'd8;
         if_id_n.bd    = id_is_jb;
         if_id_n.valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q    <= RESET_PC;
         if_id_q <= '0;
      end else begin
         pc_q    <= npc;
         if_id_q <= if_id_n;
      end
   end

`ifdef FETCH_ADDR_CHECK_EN
   logic exc_q;

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         exc_q <= 1'b0;
      end else if (!stall) begin
         exc_q <= fetch_err;
      end
   end

   assign exc_d     = exc_q;
   assign exccode_d = exc_q ? EXC_ADEL : '0;
`else
   assign exc_d     = 1'b0;
   assign exccode_d = '0;
`endif

   assign pc_f    = pc_q;
   assign instr_d = if_id_q.instr;
   assign pc_d    = if_id_q.pc;
   assign pc8_d   = if_id_q.pc8;
   assign bd_d    = if_id_q.bd;
   assign valid_d = if_id_q.valid;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline: owns the program counter and the IF/ID pipeline register.
- Drives the word-address PC into the combinational instruction memory and latches the returned instruction into IF/ID for decode.
- Arbitrates next-PC among sequential, branch/jump, exception vector and ERET redirect; tags fetch address errors (AdEL).

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
EXC_VECTOR, 32'h0000_4180, handler entry loaded on exception
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_WORDS, 2048, instruction memory depth in words; legal range IM_BASE .. IM_BASE+4*IM_WORDS-4

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset
stall  in  1  hazard unit: hold PC and IF/ID
npc_sel  in  1  ID-stage redirect valid (taken branch or jump)
npc_target  in  32  ID-stage redirect address
id_is_jb  in  1  instruction currently in ID is a branch/jump (marks next fetch as delay slot)
exc_req  in  1  CP0: take exception this cycle
eret  in  1  ERET committing this cycle
epc  in  32  CP0 EPC value
pc_f  out  32  current fetch address to instruction memory
instr_f  in  32  instruction word returned for pc_f (combinational)
instr_d  out  32  IF/ID instruction
pc_d  out  32  IF/ID PC
pc8_d  out  32  IF/ID PC+8 (link address)
bd_d  out  1  IF/ID instruction is in a delay slot
exc_d  out  1  IF/ID fetch address error pending
exccode_d  out  5  5'd4 (AdEL) when exc_d, else 0
valid_d  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (reset_n=0 at an edge): pc_f=RESET_PC; instr_d=0, pc_d=0, pc8_d=0, bd_d=0, exc_d=0, exccode_d=0, valid_d=0. Reset overrides every other input.
- Next-PC priority, highest first: exc_req -> EXC_VECTOR; eret -> epc; stall -> hold; npc_sel -> npc_target; else pc_f+4. Arithmetic is 32-bit modulo 2^32.
- IF/ID update on the same edge:
  - exc_req or eret: flush. instr_d=0, valid_d=0, bd_d=0, exc_d=0; pc_d=0, pc8_d=0. Flush wins over stall.
  - stall (no flush): all IF/ID fields hold.
  - otherwise: instr_d=instr_f, pc_d=pc_f, pc8_d=pc_f+8, bd_d=id_is_jb, valid_d=1.
- Fetch address error: pc_f[1:0]!=0, pc_f<IM_BASE, or pc_f>IM_BASE+4*IM_WORDS-4.
  - When latched: exc_d=1, exccode_d=4, instr_d=0 (nop); pc_d/pc8_d carry the faulting address.
  - PC advances normally; CP0 raises exc_req when the instruction reaches M.
- Latency: instruction at pc_f appears on instr_d one edge later. A redirect on npc_sel lands one edge later; the delay-slot instruction already fetched is kept with bd_d=1.
- Simultaneous exc_req+eret: exc_req wins. npc_sel during stall is ignored; ID re-presents it.
- Reset mid-stall or mid-redirect: state returns to reset values; no pending redirect survives.

Optional Feature:
- FETCH_ADDR_CHECK_EN defined: alignment and range checking as above.
- Undefined: exc_d and exccode_d are tied to 0, instr_d always equals instr_f, and no range comparators are built.

Decomposition:
- Shared package cpu_pkg holds RESET_PC, EXC_VECTOR, IM_BASE, IM_WORDS, EXC_ADEL=5'd4, and the IF/ID field width constants.
- One natural sub-module, fetch_npc_mux: the combinational next-PC priority selector. PC register and IF/ID register stay in fetch_stage.

Test Plan:
- Reset held 2 cycles, then released with memory returning 32'h2408_0001 -> pc_f=3000,3004,3008; instr_d=24080001 and pc_d=3000 one edge after release; valid_d=1.
- stall=1 for 3 cycles at pc_f=300C -> pc_f and all IF/ID fields frozen; after release pc_f=3010 with no duplicated or lost instruction.
- Branch at pc_d=3010, npc_sel=1, npc_target=3040, id_is_jb=1 -> next cycle pc_d=3014 with bd_d=1; following cycle pc_f=3040, then pc_d=3040 with bd_d=0.
- exc_req=1 together with stall=1 at pc_f=3020 -> pc_f=4180, valid_d=0, instr_d=0 on next edge.
- With FETCH_ADDR_CHECK_EN: npc_target=3042, then separately pc_f reaching 4FFC -> 5000 -> exc_d=1, exccode_d=4, instr_d=0, pc_d=3042 / 5000 respectively.
- eret=1, epc=3058 -> pc_f=3058, IF/ID flushed; with exc_req also asserted, pc_f=4180.
